// File: rtl/magma_pkg.sv
// Shared Magma (GOST R 34.12-2015) constants, S-boxes and round helpers
// used by both the encoder and the iterative decoder.
package magma_pkg;

    localparam int MAGMA_ROUNDS  = 32;
    localparam int MAGMA_BLOCK_W = 64;
    localparam int MAGMA_KEY_W   = 256;

    typedef logic [1:0] magma_state_t;

    localparam magma_state_t ST_IDLE = 2'd0;
    localparam magma_state_t ST_RUN  = 2'd1;
    localparam magma_state_t ST_DONE = 2'd2;

    // Row j is pi'_j, applied to nibble [4j+3:4j].
    localparam logic [3:0] MAGMA_PI [0:7][0:15] = '{
        '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,  4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1 },
        '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
        '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13, 4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0 },
        '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,  4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
        '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13, 4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
        '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10, 4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0 },
        '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12, 4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7 },
        '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,  4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2 }
    };

    function automatic logic [31:0] magma_t(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[4*j +: 4] = MAGMA_PI[j][a[4*j +: 4]];
        end
        return r;
    endfunction

    function automatic logic [31:0] magma_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s;
        s = magma_t(a + k);
        return {s[20:0], s[31:21]};
    endfunction

    // Decryption schedule: K1..K8 for rounds 0..7, then K8..K1 repeated.
    function automatic logic [31:0] magma_dec_round_key(input logic [MAGMA_KEY_W-1:0] key,
                                                        input logic [4:0] rnd);
        logic [2:0]             idx;
        logic [2:0]             from_lsb;
        logic [MAGMA_KEY_W-1:0] sh;
        idx      = (rnd < 5'd8) ? rnd[2:0] : (3'd7 - rnd[2:0]);
        from_lsb = 3'd7 - idx;
        sh       = key >> {from_lsb, 5'd0};
        return sh[31:0];
    endfunction

endpackage

// File: rtl/magma_decoder_if.sv
// Ready/valid block interface between a ciphertext source, the decoder and
// the plaintext consumer.
interface magma_decoder_if;
    import magma_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [MAGMA_BLOCK_W-1:0] block;
    logic [MAGMA_KEY_W-1:0]   key;
    logic                     out_valid;
    logic                     out_ready;
    logic [MAGMA_BLOCK_W-1:0] decoded;

    modport master (
        output in_valid, block, key, out_ready,
        input  in_ready, out_valid, decoded
    );

    modport slave (
        input  in_valid, block, key, out_ready,
        output in_ready, out_valid, decoded
    );

endinterface

// File: rtl/magma_round.sv
// One combinational Magma Feistel round; the last round skips the half swap.
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] a1_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] k_i,
    input  logic        last_i,
    output logic [31:0] a1_o,
    output logic [31:0] a0_o
);

    logic [31:0] mix;

    always_comb begin
        mix = magma_g(a0_i, k_i) ^ a1_i;
        if (last_i) begin
            a1_o = mix;
            a0_o = a0_i;
        end else begin
            a1_o = a0_i;
            a0_o = mix;
        end
    end

endmodule

// File: rtl/magma_decoder.sv
// Iterative Magma decryption core: one Feistel round per clock, one block in
// flight, ready/valid on both sides.
module magma_decoder
    import magma_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    magma_decoder_if.slave  bus
);

    magma_state_t             state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [MAGMA_BLOCK_W-1:0] dec_q, dec_d;
    logic [31:0]              a1_q, a0_q;
    logic [MAGMA_KEY_W-1:0]   key_q;

    logic        load;
    logic        step;
    logic        last_rnd;
    logic [31:0] rnd_a1, rnd_a0;
    logic [31:0] rnd_k;

    assign last_rnd = (cnt_q == 5'(MAGMA_ROUNDS - 1));
    assign rnd_k    = magma_dec_round_key(key_q, cnt_q);

    magma_round u_round (
        .a1_i   (a1_q),
        .a0_i   (a0_q),
        .k_i    (rnd_k),
        .last_i (last_rnd),
        .a1_o   (rnd_a1),
        .a0_o   (rnd_a0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (last_rnd) begin
                    dec_d   = {rnd_a1, rnd_a0};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    // Round state and key copy need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            a1_q  <= bus.block[63:32];
            a0_q  <= bus.block[31:0];
            key_q <= bus.key;
        end else if (step) begin
            a1_q  <= rnd_a1;
            a0_q  <= rnd_a0;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.decoded   = dec_q;

endmodule

// File: tb/tb_magma_decoder.sv
// Scoreboard bench for magma_decoder with an independent Magma encryption
// reference used to build ciphertexts.
module tb_magma_decoder;

    logic clk;
    logic rst_n;
    int   cycle;
    int   n_tests;
    int   n_fail;
    logic [63:0] exp_q[$];

    localparam logic [63:0]  STD_CT  = 64'h4ee901e5c2d8ca3d;
    localparam logic [63:0]  STD_PT  = 64'hfedcba9876543210;
    localparam logic [255:0] STD_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    magma_decoder_if bus();

    magma_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference S-boxes, kept separate from the design package.
    logic [3:0] sbox [0:7][0:15];
    initial begin
        sbox[0] = '{12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1};
        sbox[1] = '{6,8,2,3,9,10,5,12,1,14,4,7,11,13,0,15};
        sbox[2] = '{11,3,5,8,2,15,10,13,14,1,7,4,12,9,6,0};
        sbox[3] = '{12,8,2,1,13,4,15,6,7,0,10,5,3,14,9,11};
        sbox[4] = '{7,15,5,10,8,1,6,13,0,9,3,14,11,4,2,12};
        sbox[5] = '{5,13,15,6,9,2,12,10,11,7,8,1,4,3,14,0};
        sbox[6] = '{8,14,2,5,6,9,1,12,15,4,11,0,13,10,3,7};
        sbox[7] = '{1,7,14,13,0,5,8,3,4,15,10,6,9,12,11,2};
    end

    function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s, t;
        s = a + k;
        for (int j = 0; j < 8; j++) t[4*j +: 4] = sbox[j][s[4*j +: 4]];
        return (t << 11) | (t >> 21);
    endfunction

    function automatic logic [31:0] ref_key(input logic [255:0] key, input int j);
        logic [255:0] sh;
        sh = key >> (32 * (7 - j));
        return sh[31:0];
    endfunction

    // Encryption: K1..K8 three times, then K8..K1.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [255:0] key);
        logic [31:0] a1, a0, tmp, k;
        a1 = pt[63:32];
        a0 = pt[31:0];
        for (int i = 0; i < 32; i++) begin
            k = (i < 24) ? ref_key(key, i % 8) : ref_key(key, 7 - (i % 8));
            if (i == 31) begin
                a1 = ref_g(a0, k) ^ a1;
            end else begin
                tmp = ref_g(a0, k) ^ a1;
                a1  = a0;
                a0  = tmp;
            end
        end
        return {a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block and returns once the acceptance edge has passed.
    task automatic accept(input logic [63:0] blk, input logic [255:0] k, output bit ok);
        int n;
        bit rdy;
        bus.block    = blk;
        bus.key      = k;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            rdy = bus.in_ready;
            tick();
            n++;
            if (rdy) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.decoded !== 64'h0) begin
            $display("FAIL reset_state: in_ready=%b out_valid=%b decoded=%h, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.decoded);
            n_fail++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_standard();
        bit ok;
        int lat;
        logic [63:0] exp;
        exp_q.push_back(STD_PT);
        accept(STD_CT, STD_KEY, ok);
        n_tests++;
        if (!ok) begin
            $display("FAIL std_accept: no acceptance within bound");
            n_fail++;
        end
        wait_out(lat);
        n_tests++;
        if (lat !== 32) begin
            $display("FAIL std_latency: got %0d cycles, want 32", lat);
            n_fail++;
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.decoded !== exp) begin
            $display("FAIL std_decoded: got %h, want %h", bus.decoded, exp);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL std_return_idle: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        bit stable;
        logic [63:0] held, exp;
        bus.out_ready = 1'b0;
        exp_q.push_back(STD_PT);
        accept(STD_CT, STD_KEY, ok);
        wait_out(lat);
        held   = bus.decoded;
        stable = 1'b1;
        bus.block    = 64'h0123456789abcdef;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.decoded !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        n_tests++;
        if (!stable) begin
            $display("FAIL bp_hold: decoded=%h out_valid=%b in_ready=%b, want %h 1 0",
                     bus.decoded, bus.out_valid, bus.in_ready, held);
            n_fail++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp = exp_q.pop_front();
        n_tests++;
        if (bus.decoded !== exp) begin
            $display("FAIL bp_decoded: got %h, want %h", bus.decoded, exp);
            n_fail++;
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
            n_fail++;
        end
    endtask

    task automatic test_key_change();
        bit ok;
        int lat;
        logic [63:0] exp;
        exp_q.push_back(STD_PT);
        accept(STD_CT, STD_KEY, ok);
        bus.key   = '1;
        bus.block = '1;
        wait_out(lat);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat >= 100 || bus.decoded !== exp) begin
            $display("FAIL key_change: got %h (lat %0d), want %h", bus.decoded, lat, exp);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_round_trip();
        bit ok;
        int lat;
        int bad;
        logic [63:0]  pt, exp;
        logic [255:0] k;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            pt = {$urandom, $urandom};
            for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
            exp_q.push_back(pt);
            accept(ref_encrypt(pt, k), k, ok);
            wait_out(lat);
            exp = exp_q.pop_front();
            n_tests++;
            if (!ok || lat >= 100 || bus.decoded !== exp) begin
                $display("FAIL round_trip[%0d]: got %h, want %h", n, bus.decoded, exp);
                n_fail++;
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        logic [63:0] exp;
        accept(STD_CT ^ 64'h1, STD_KEY, ok);
        repeat (15) tick();
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL mid_run_busy: in_ready=%b, want 0", bus.in_ready);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.decoded !== 64'h0) begin
            $display("FAIL mid_run_reset: out_valid=%b in_ready=%b decoded=%h, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.decoded);
            n_fail++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(STD_PT);
        accept(STD_CT, STD_KEY, ok);
        wait_out(lat);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat !== 32 || bus.decoded !== exp) begin
            $display("FAIL after_reset: got %h (lat %0d), want %h (lat 32)", bus.decoded, lat, exp);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0]  p1, p2, exp;
        logic [255:0] k1, k2;
        int c1, c2, got, n;
        bit r, ov;
        p1 = 64'h1122334455667788;
        p2 = 64'h99aabbccddeeff00;
        k1 = STD_KEY;
        k2 = ~STD_KEY;
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        bus.block    = ref_encrypt(p1, k1);
        bus.key      = k1;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        c1 = cycle;
        bus.block = ref_encrypt(p2, k2);
        bus.key   = k2;
        c2  = -1;
        got = 0;
        n   = 0;
        while (got < 2 && n < 200) begin
            r  = bus.in_ready;
            ov = bus.out_valid;
            if (ov) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                n_tests++;
                if (bus.decoded !== exp) begin
                    $display("FAIL b2b_out[%0d]: got %h, want %h", got, bus.decoded, exp);
                    n_fail++;
                end
                got++;
            end
            tick();
            n++;
            if (r && c2 < 0) begin
                c2 = cycle;
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (got != 2 || c2 - c1 != 34) begin
            $display("FAIL b2b_spacing: outputs=%0d spacing=%0d, want 2 and 34", got, c2 - c1);
            n_fail++;
        end
        tick();
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.block     = '0;
        bus.key       = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_standard();
        test_backpressure();
        test_key_change();
        test_round_trip();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/magma_decoder.md
# magma_decoder

Iterative GOST R 34.12-2015 Magma (64-bit block, 256-bit key) decryption core, the inverse of the pipelined Magma encoder. It runs one Feistel round per clock over 32 rounds. Ready/valid handshakes on input and output let it sit behind the encoder output or any 64-bit ciphertext stream. It trades throughput for area: one round datapath, one block in flight.

## Interface
- Parameters: none. Block width 64, key width 256, and round count 32 are fixed constants.
- Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext block and key present
- in_ready  out  1  core can accept a block
- block  in  64  ciphertext; bits [63:32] = a1, bits [31:0] = a0
- key  in  256  key K; bits [255:224] = K1 … bits [31:0] = K8
- out_valid  out  1  decoded block available
- out_ready  in  1  consumer accepts decoded
- decoded  out  64  plaintext; same bit layout as block

## Operation
- Reset values: in_ready=1, out_valid=0, decoded=0, round counter=0, FSM=IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, latch block into (a1,a0) and key into an internal register, clear round counter, and go to RUN. The key input is don't-care after acceptance.
- RUN: in_ready=0. Each cycle applies round i (i = counter, 0..31) and increments the counter. After round 31, load decoded and go to DONE.
- Round function: g(a,k) = rotl11(t((a + k) mod 2^32)).
  - t: eight 4-bit S-boxes (pi'_0 on nibble [3:0] … pi'_7 on [31:28]).
  - Rounds 0..30: (a1,a0) <= (a0, g(a0,k) ^ a1).
  - Round 31: no swap; result = {g(a0,k) ^ a1, a0}.
- Decryption key order: round i uses K(i+1) for i<8, else K(8 − (i mod 8)). That gives K1..K8, then K8..K1 three times.
- DONE: out_valid=1, and decoded holds steady until out_valid && out_ready. The handshake returns the FSM to IDLE.
- in_valid during RUN or DONE is ignored; the upstream holds until in_ready.
- Addition is a 32-bit wrap-around; the carry is discarded.

## Timing
- Acceptance edge = T. Round i is registered at edge T+1+i, so out_valid rises after edge T+32.
- Latency from acceptance to out_valid is 32 cycles.
- With out_ready held high, the output handshake occurs at T+33. in_ready returns after that edge, and the next acceptance is no earlier than T+34. Minimum period is 34 cycles per block.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset asserted mid-RUN or in DONE:
  - all outputs return to their reset values immediately (asynchronously);
  - the block in flight is dropped.
- Reset deasserts synchronously to clk (handled by the external reset synchronizer).

## Structure
- Package magma_pkg holds the items shared with the encoder:
  - the standard pi'_0..pi'_7 S-box constants;
  - function t(), function g(), and a round-key select function.
- Also in magma_pkg: localparams MAGMA_ROUNDS=32, MAGMA_BLOCK_W=64, MAGMA_KEY_W=256, and the FSM state typedef.
- Sub-module magma_round is a combinational single round with inputs a1, a0, k, and last, and outputs a1', a0'. It is shared with the encoder stage logic.
- Top level contains only the FSM, counter, and registers.

## Test plan
- Standard vector: block=64'h4ee901e5c2d8ca3d, key=256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff → decoded=64'hfedcba9876543210, with out_valid exactly 32 cycles after acceptance.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → decoded stays stable, in_ready stays 0, and in_valid is ignored. Release → one handshake, then in_ready=1 on the next cycle.
- Key/block change after acceptance: overwrite key with all-ones on the cycle after acceptance → result is still 64'hfedcba9876543210.
- Round trip: 20 random (block, key) pairs through MagmaEncoder, then magma_decoder → decoded equals the original block for every pair.
- Reset mid-RUN: assert rst_n=0 at round 15 → out_valid=0, in_ready=1, decoded=0 immediately. After release, the standard vector decodes correctly.
- Back-to-back: two blocks offered with in_valid held high and out_ready=1 → acceptances 34 cycles apart, and both outputs are correct and in order.
